// File: rtl/vmm_pkg.sv
// Shared constants, FSM state type and the word x weight product helper for the VMM serial MAC.
package vmm_pkg;

  localparam int DW     = 10;
  localparam int WW     = 8;
  localparam int NWORDS = 4;
  localparam int PW     = DW + WW + 1;
  localparam int ACC_W  = DW + WW + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Unsigned word times signed weight. Both operands are widened to the product width
  // first, so the multiply is exact and never wraps.
  function automatic logic signed [PW-1:0] word_product(input logic [DW-1:0] d,
                                                        input logic signed [WW-1:0] w);
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] w_ext;
    d_ext = {{WW{1'b0}}, d};
    w_ext = {{(DW+1){w[WW-1]}}, w};
    word_product = d_ext * w_ext;
  endfunction

endpackage

// File: rtl/vmm_weight_regfile.sv
// Four signed weight registers: one write port and four parallel read ports. Writes take effect at the edge.
// Reads always return the value held before that edge. There is no backpressure.
module vmm_weight_regfile
  import vmm_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          w_we,
  input  logic [1:0]    w_addr,
  input  logic [WW-1:0] w_data,
  output logic [WW-1:0] w0,
  output logic [WW-1:0] w1,
  output logic [WW-1:0] w2,
  output logic [WW-1:0] w3
);

  logic [WW-1:0] regs [NWORDS];

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
    end else if (w_we) begin
      regs[w_addr] <= w_data;
    end
  end

  assign w0 = regs[0];
  assign w1 = regs[1];
  assign w2 = regs[2];
  assign w3 = regs[3];

endmodule

// File: rtl/vmm_serial_mac.sv
// Four-word serial dot product (word k x weight[3-k]). The result registers at the edge that samples word 3. There is no backpressure.
// Optional VMM_MAC_RELU_EN: clamps negative results to 0 before acc_out is registered.
module vmm_serial_mac
  import vmm_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic             frame_start,
  input  logic             w_we,
  input  logic [1:0]       w_addr,
  input  logic [WW-1:0]    w_data,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             frame_err
);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_err_q, frame_err_d;

  logic [WW-1:0]           w0, w1, w2, w3;
  logic signed [WW-1:0]    w_sel;
  logic [1:0]              word_idx;
  logic                    start;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] result;

  vmm_weight_regfile u_weights (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w0      (w0),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3)
  );

  assign start = din_valid & frame_start;

  // A frame_start word is always word 0, even when it aborts a partial frame.
  assign word_idx = start ? 2'd0 : cnt_q;

  always_comb begin
    w_sel = w3;
    case (word_idx)
      2'd0: w_sel = w3;
      2'd1: w_sel = w2;
      2'd2: w_sel = w1;
      2'd3: w_sel = w0;
      default: w_sel = w3;
    endcase
  end

  assign prod     = word_product(din, w_sel);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign sum      = acc_q + prod_ext;

`ifdef VMM_MAC_RELU_EN
  assign result = sum[ACC_W-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = 2'd0;
        if (start) begin
          acc_d   = prod_ext;
          cnt_d   = 2'd1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          frame_err_d = 1'b1;
          acc_d       = prod_ext;
          cnt_d       = 2'd1;
        end else if (din_valid) begin
          if (cnt_q == 2'd3) begin
            acc_out_d   = result;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = 2'd0;
            state_d     = IDLE;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_vmm_serial_mac.sv
// Randomised and directed bench for vmm_serial_mac against a frame-level arithmetic model.
module tb_vmm_serial_mac;
  import vmm_pkg::*;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic             frame_start;
  logic             w_we;
  logic [1:0]       w_addr;
  logic [WW-1:0]    w_data;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             frame_err;

  vmm_serial_mac dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .frame_err   (frame_err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: weights, words seen in the open frame, running sum, last result.
  int wm [4];
  int nw;
  int psum;
  int exp_acc;
  bit exp_vld;
  bit exp_err;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int relu(input int s);
`ifdef VMM_MAC_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    check("acc_out", 32'($signed(acc_out)), exp_acc);
  endtask

  task automatic step(input bit v, input bit fs, input int d,
                      input bit we = 1'b0, input int a = 0, input int wd = 0);
    din         = 10'(d);
    din_valid   = v;
    frame_start = fs;
    w_we        = we;
    w_addr      = 2'(a);
    w_data      = 8'(wd);
    @(posedge CLK);
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (v && fs) begin
      exp_err = (nw != 0);
      psum    = d * wm[3];
      nw      = 1;
    end else if (v && nw != 0) begin
      psum += d * wm[3 - nw];
      nw++;
      if (nw == 4) begin
        exp_acc = relu(psum);
        exp_vld = 1'b1;
        nw      = 0;
      end
    end
    if (we) wm[a] = wd;
    #1;
    check_outputs();
  endtask

  task automatic set_weights(input int a0, input int a1, input int a2, input int a3);
    step(0, 0, 0, 1, 0, a0);
    step(0, 0, 0, 1, 1, a1);
    step(0, 0, 0, 1, 2, a2);
    step(0, 0, 0, 1, 3, a3);
  endtask

  task automatic frame4(input int d0, input int d1, input int d2, input int d3);
    step(1, 1, d0);
    step(1, 0, d1);
    step(1, 0, d2);
    step(1, 0, d3);
  endtask

  task automatic idle();
    step(0, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) wm[i] = 0;
    nw      = 0;
    psum    = 0;
    exp_acc = 0;
    exp_vld = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    Reset_n     = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge CLK);
    Reset_n = 1'b1;

    // Basic dot product.
    set_weights(1, 2, 3, 4);
    frame4(400, 300, 200, 100);
    idle();
    check("basic_result", 32'($signed(acc_out)), relu(3000));

    // Negative sum.
    set_weights(-1, -1, -1, -1);
    frame4(1023, 1023, 1023, 1023);
    idle();
    check("neg_result", 32'($signed(acc_out)), relu(-4092));

    // Extremes: no wrap.
    set_weights(-128, -128, -128, -128);
    frame4(1023, 1023, 1023, 1023);
    check("min_extreme", 32'($signed(acc_out)), relu(-523776));
    set_weights(127, 127, 127, 127);
    frame4(1023, 1023, 1023, 1023);
    check("max_extreme", 32'($signed(acc_out)), 519684);

    // Gapped frame followed by a back-to-back frame.
    set_weights(5, -7, 9, -11);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) step(0, 0, int'($urandom_range(0, 1023)));
      step(1, k == 0, int'($urandom_range(0, 1023)));
    end
    frame4(11, 22, 33, 44);
    check("b2b_result", 32'($signed(acc_out)), relu(11 * -11 + 22 * 9 + 33 * -7 + 44 * 5));
    idle();

    // Premature frame_start, then a new frame with a same-cycle write to weight 3.
    step(1, 1, 100);
    step(1, 0, 200);
    step(1, 1, 50, 1, 3, 100);
    check("err_pulse", {31'd0, frame_err}, 32'd1);
    step(1, 0, 60);
    step(1, 0, 70);
    step(1, 0, 80);
    check("err_recover", 32'($signed(acc_out)), relu(50 * -11 + 60 * 9 + 70 * -7 + 80 * 5));
    idle();

    // Asynchronous reset mid-frame.
    step(1, 1, 500);
    step(1, 0, 600);
    din_valid = 1'b0;
    frame_start = 1'b0;
    w_we = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    Reset_n = 1'b1;
    set_weights(2, -3, 4, -5);
    frame4(10, 20, 30, 40);
    check("post_reset", 32'($signed(acc_out)), relu(10 * -5 + 20 * 4 + 30 * -3 + 40 * 2));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, fs, we;
      v  = ($urandom_range(0, 99) < 70);
      fs = v && ((nw == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0));
      we = ($urandom_range(0, 4) == 0);
      step(v, fs, int'($urandom_range(0, 1023)), we, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vmm_serial_mac.md
# vmm_serial_mac

Downstream consumer of the VMM input serializer. Receives the 10-bit word stream (four words per frame, highest-index word first) and multiplies each word by a locally stored signed weight. Accumulates the four products into one dot-product result with a one-cycle valid pulse. Sits between the SPI-side serializer and the VMM result collection logic.

## Interface
- DW, 10: input word width (unsigned), matches serializer output.
- WW, 8: weight width (signed two's complement).
- NWORDS, 4: words per frame; fixed at 4 (counter is 2 bits).
- ACC_W, DW+WW+2: accumulator/output width (signed).
- CLK  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- din  input  DW  serial data word from upstream serializer.
- din_valid  input  1  din is valid this cycle.
- frame_start  input  1  qualifies din as word 0 of a frame (only with din_valid=1).
- w_we  input  1  weight write enable.
- w_addr  input  2  weight index 0..3.
- w_data  input  WW  weight value.
- acc_out  output  ACC_W  signed dot-product result, held until next result.
- out_valid  output  1  one-cycle pulse: acc_out updated.
- frame_err  output  1  one-cycle pulse: frame aborted by premature frame_start.

## Operation
- Word k of a frame (k=0..3) is upstream slot din_reg[3-k] and multiplies weight[3-k].
- Product: zero-extended din times sign-extended weight, DW+WW+1 bits signed; sum of four products sign-extended to ACC_W, so it can never overflow.
- FSM states: IDLE, ACCUM.
  - IDLE: acc cleared. Sampled din_valid&frame_start loads acc=product(word0), cnt=1, goes to ACCUM. din_valid without frame_start is ignored.
  - ACCUM: each din_valid without frame_start adds product(word cnt) and increments cnt. On word 3: acc_out<=acc+product, out_valid=1, cnt=0, return to IDLE.
  - ACCUM with din_valid&frame_start: frame_err=1, partial sum discarded, and a new frame starts with this word as word 0 (cnt=1). acc_out is unchanged.
- Gaps (din_valid=0) are allowed anywhere in a frame; state and acc hold.
- Weights: 4 x WW registers. w_we writes at the edge. A write and a use of the same index in the same cycle use the old weight; the new value applies from the next sampled word.
- Reset (async, any time, including mid-frame): acc=0, cnt=0, state=IDLE, acc_out=0, out_valid=0, frame_err=0, all weights=0. Partial frame is lost; no out_valid is produced for it.

## Timing
- Sampling on rising CLK. acc_out and out_valid update at the same edge that samples word 3, so out_valid is high in the following cycle. Latency from word 3 is one edge.
- out_valid and frame_err are single-cycle pulses; no backpressure. Back-to-back frames (word 0 sampled the cycle after word 3) are supported at full rate: one result per 4 valid cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- VMM_MAC_RELU_EN defined: negative final sums are clamped to 0 before acc_out is registered. out_valid timing is unchanged.
- Not defined: acc_out is the raw signed sum.

## Structure
- Shared package vmm_pkg: DW, WW, NWORDS, ACC_W defaults; FSM state enum (IDLE, ACCUM).
- Sub-module vmm_weight_regfile: 4 x WW registers, one write port (w_we/w_addr/w_data), four parallel read outputs, async active-low reset to 0.
- Top holds FSM, counter, multiplier, accumulator and output registers.

## Test plan
- Weights [w0..w3]=[1,2,3,4]; frame 400,300,200,100 with frame_start on 400 -> acc_out=3000, out_valid one cycle after the edge sampling 100.
- All weights -1, four words of 1023 -> acc_out=-4092 (without RELU); with VMM_MAC_RELU_EN -> 0.
- Extremes: weights -128, words 1023 -> -523776; weights 127 -> 519684; no wrap.
- Frame with din_valid gaps of 0-3 cycles, then a back-to-back frame -> two correct results, pulses exactly 4 valid words apart.
- frame_start after 2 words -> frame_err pulse, acc_out unchanged, new frame completes correctly. w_we to index 3 in the same cycle as word 0 -> old w3 used.
- Reset_n low after word 1 -> all outputs 0 immediately. Next frame after release produces a correct sum with weights re-written.
